// File: rtl/ram_be_pkg.sv
// Shared definitions for the byte-enable RAM: lane width, FSM states and the
// legal read-latency range. No ports.
// Latency: n/a. Backpressure: n/a.
package ram_be_pkg;

  localparam int LANE_W       = 8;
  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  function automatic bit read_lat_ok(input int lat);
    return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
  endfunction

endpackage

// File: rtl/ram_be_if.sv
// Access bus of the byte-enable RAM: address/select/strobes in, read data,
// read_valid and busy out. master = requester (MEM stage), slave = ram_be.
// Latency: n/a. Backpressure: none; busy simply causes accesses to be ignored.
interface ram_be_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);

  logic [ADDR_W-1:0]   addr;
  logic                cs;
  logic                rd;
  logic                oe;
  logic [DATA_W/8-1:0] be;
  logic [DATA_W-1:0]   write_data;
  logic [DATA_W-1:0]   read_data;
  logic                read_valid;
  logic                busy;

  modport master (
    output addr, cs, rd, oe, be, write_data,
    input  read_data, read_valid, busy
  );

  modport slave (
    input  addr, cs, rd, oe, be, write_data,
    output read_data, read_valid, busy
  );

endinterface

// File: rtl/ram_be_array.sv
// Storage for ram_be: 2**ADDR_W x DATA_W words, byte-lane write enables,
// synchronous read into a data register (reset to 0; array itself not reset).
// Ports: clk_i, rst_i, we_i, be_i, addr_i, wdata_i, re_i, rdata_o.
// Latency: 1 cycle read. Backpressure: none.
module ram_be_array
  import ram_be_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [DATA_W/LANE_W-1:0] be_i,
  input  logic [ADDR_W-1:0]        addr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic                     re_i,
  output logic [DATA_W-1:0]        rdata_o
);

  localparam int NB    = DATA_W / LANE_W;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Array has no reset so it maps onto plain RAM macros.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < NB; i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][i*LANE_W +: LANE_W] <= wdata_i[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_be.sv
// Parametrised single-port RAM with byte strobes, zero-fill-after-reset
// sequencer, READ_LAT (1|2) read pipeline and read_valid strobe.
// Ports: clk, rst (async, active-high), bus (ram_be_if.slave).
// Latency: read data/read_valid READ_LAT cycles after the read edge.
// Backpressure: none; while busy (reset or clearing) accesses are dropped.
module ram_be
  import ram_be_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 10,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic     clk,
  input  logic     rst,
  ram_be_if.slave  bus
);

  localparam int     NB        = DATA_W / LANE_W;
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  if (!read_lat_ok(READ_LAT) || ((DATA_W % LANE_W) != 0)) begin : g_param_err
    $error("ram_be: DATA_W must be a multiple of 8 and READ_LAT must be 1 or 2");
  end

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;
  logic              rvld_q;

  logic              clearing;
  logic              do_wr;
  logic              do_rd;
  logic              arr_we;
  logic [NB-1:0]     arr_be;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] data_out;
  logic              rvalid;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_CLEAR) begin
      // Pointer parks on the last word; it only returns to 0 through reset.
      if (ptr_q == {ADDR_W{1'b1}}) begin
        state_d = ST_RUN;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
    busy_d = (state_d == ST_CLEAR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_STATE;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
      rvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      rvld_q  <= do_rd;
    end
  end

  // busy_q (not state) gates accesses so the first cycle after a no-clear
  // reset release is also locked out.
  assign clearing = (state_q == ST_CLEAR);
  assign do_wr    = bus.cs && !busy_q && !bus.rd;
  assign do_rd    = bus.cs && !busy_q &&  bus.rd;

  // Clear mux: the sequencer owns the write port while clearing. Writes are
  // held off during rst so reset itself never touches the array.
  assign arr_we    = !rst && (clearing || do_wr);
  assign arr_be    = clearing ? {NB{1'b1}} : bus.be;
  assign arr_addr  = clearing ? ptr_q : bus.addr;
  assign arr_wdata = clearing ? '0 : bus.write_data;

  ram_be_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (arr_we),
    .be_i    (arr_be),
    .addr_i  (arr_addr),
    .wdata_i (arr_wdata),
    .re_i    (do_rd),
    .rdata_o (rdata)
  );

  if (READ_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] pipe_q;
    logic              vld2_q;

    // Pipe register only loads on a real read so it holds between reads.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pipe_q <= '0;
        vld2_q <= 1'b0;
      end else begin
        vld2_q <= rvld_q;
        if (rvld_q) begin
          pipe_q <= rdata;
        end
      end
    end

    assign data_out = pipe_q;
    assign rvalid   = vld2_q;
  end else begin : g_lat1
    assign data_out = rdata;
    assign rvalid   = rvld_q;
  end

  assign bus.read_data  = bus.oe ? data_out : '0;
  assign bus.read_valid = rvalid;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_ram_be.sv
// Bench for ram_be: three instances (default, READ_LAT=2 narrow, no-clear
// 16-bit) with a read scoreboard per instance popped on read_valid.
module tb_ram_be;

  logic        clk;
  logic        rst;
  logic [9:0]  addr;
  logic        cs, rd, oe;
  logic [3:0]  be;
  logic [31:0] wdat;
  logic [3:0]  c_addr;
  logic        c_cs, c_rd;
  logic [1:0]  c_be;
  logic [15:0] c_wdat;

  int checks = 0;
  int errors = 0;
  int n, nb, nc;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] qc[$];

  ram_be_if #(.DATA_W(32), .ADDR_W(10)) bus_a ();
  ram_be_if #(.DATA_W(32), .ADDR_W(4))  bus_b ();
  ram_be_if #(.DATA_W(16), .ADDR_W(4))  bus_c ();

  assign bus_a.addr       = addr;
  assign bus_a.cs         = cs;
  assign bus_a.rd         = rd;
  assign bus_a.oe         = oe;
  assign bus_a.be         = be;
  assign bus_a.write_data = wdat;

  assign bus_b.addr       = addr[3:0];
  assign bus_b.cs         = cs;
  assign bus_b.rd         = rd;
  assign bus_b.oe         = oe;
  assign bus_b.be         = be;
  assign bus_b.write_data = wdat;

  assign bus_c.addr       = c_addr;
  assign bus_c.cs         = c_cs;
  assign bus_c.rd         = c_rd;
  assign bus_c.oe         = oe;
  assign bus_c.be         = c_be;
  assign bus_c.write_data = c_wdat;

  ram_be #(.DATA_W(32), .ADDR_W(10), .READ_LAT(1), .CLEAR_ON_RESET(1)) u_a (
    .clk (clk), .rst (rst), .bus (bus_a));
  ram_be #(.DATA_W(32), .ADDR_W(4), .READ_LAT(2), .CLEAR_ON_RESET(1)) u_b (
    .clk (clk), .rst (rst), .bus (bus_b));
  ram_be #(.DATA_W(16), .ADDR_W(4), .READ_LAT(1), .CLEAR_ON_RESET(0)) u_c (
    .clk (clk), .rst (rst), .bus (bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic spurious(input string tag, input int qsize);
    checks++;
    assert (qsize > 0) else begin
      errors++;
      $error("FAIL %s observed read_valid=1 expected read_valid=0", tag);
    end
  endtask

  // One clock: advance past the edge, then let the scoreboards consume any
  // read_valid pulses presented by the instances.
  task automatic tick();
    logic [31:0] e;
    @(posedge clk);
    #1;
    if (bus_a.read_valid) begin
      spurious("a_spurious_vld", qa.size());
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check("a_rdata", bus_a.read_data, oe ? e : 32'h0);
      end
    end
    if (bus_b.read_valid) begin
      spurious("b_spurious_vld", qb.size());
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check("b_rdata", bus_b.read_data, oe ? e : 32'h0);
      end
    end
    if (bus_c.read_valid) begin
      spurious("c_spurious_vld", qc.size());
      if (qc.size() > 0) begin
        e = qc.pop_front();
        check("c_rdata", {16'h0, bus_c.read_data}, oe ? e : 32'h0);
      end
    end
  endtask

  task automatic op_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
    cs = 1'b1; rd = 1'b0; addr = a; wdat = d; be = s;
    tick();
    cs = 1'b0; be = 4'h0;
  endtask

  task automatic op_read(input logic [9:0] a, input logic [31:0] ea, input logic [31:0] eb);
    cs = 1'b1; rd = 1'b1; addr = a; be = 4'hF;
    qa.push_back(ea);
    qb.push_back(eb);
    tick();
    cs = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; cs = 1'b0; rd = 1'b0; oe = 1'b1; be = 4'h0; addr = '0; wdat = '0;
    c_cs = 1'b0; c_rd = 1'b0; c_be = 2'b00; c_addr = '0; c_wdat = '0;
    #1;
    check("rst_busy_a", {31'h0, bus_a.busy}, 32'h1);
    check("rst_busy_b", {31'h0, bus_b.busy}, 32'h1);
    check("rst_busy_c", {31'h0, bus_c.busy}, 32'h1);
    check("rst_vld_a", {31'h0, bus_a.read_valid}, 32'h0);
    check("rst_vld_b", {31'h0, bus_b.read_valid}, 32'h0);
    check("rst_rdata_a", bus_a.read_data, 32'h0);
    check("rst_rdata_b", bus_b.read_data, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Reset in the middle of the clear.
    repeat (300) tick();
    check("busy_a_clear300", {31'h0, bus_a.busy}, 32'h1);
    check("busy_b_done", {31'h0, bus_b.busy}, 32'h0);
    check("busy_c_run", {31'h0, bus_c.busy}, 32'h0);
    rst = 1'b1;
    #1;
    check("async_busy_b", {31'h0, bus_b.busy}, 32'h1);
    check("async_busy_c", {31'h0, bus_c.busy}, 32'h1);
    tick();
    tick();
    rst = 1'b0;

    // Full clear length, with a write attempted while A is still busy.
    n = 0; nb = 0; nc = 0;
    do begin
      if (n == 500) begin
        cs = 1'b1; rd = 1'b0; addr = 10'd7; wdat = 32'hCAFEF00D; be = 4'hF;
      end
      if (n == 501) begin
        cs = 1'b0; be = 4'h0;
      end
      tick();
      n++;
      if (nb == 0 && !bus_b.busy) nb = n;
      if (nc == 0 && !bus_c.busy) nc = n;
    end while (bus_a.busy && n < 3000);
    check("busy_cycles_a", n, 32'd1024);
    check("busy_cycles_b", nb, 32'd16);
    check("busy_cycles_c", nc, 32'd1);

    // Cleared contents; B finished early so it accepted the addr-7 write.
    op_read(10'd0, 32'h0, 32'h0);
    op_read(10'd513, 32'h0, 32'h0);
    op_read(10'd1023, 32'h0, 32'h0);
    op_read(10'd7, 32'h0, 32'hCAFEF00D);

    // Byte strobes, write immediately followed by read.
    op_write(10'd5, 32'h11223344, 4'b1111);
    op_read(10'd5, 32'h11223344, 32'h11223344);
    op_write(10'd5, 32'hAABBCCDD, 4'b0101);
    op_read(10'd5, 32'h11BB33DD, 32'h11BB33DD);
    op_write(10'd5, 32'hFFFFFFFF, 4'b0000);
    op_read(10'd5, 32'h11BB33DD, 32'h11BB33DD);

    // Latency: A presents after the read edge, B one cycle later.
    op_write(10'd3, 32'hDEADBEEF, 4'hF);
    for (int k = 0; k < 2; k++) begin
      oe = (k == 0);
      cs = 1'b1; rd = 1'b1; addr = 10'd3;
      qa.push_back(32'hDEADBEEF);
      qb.push_back(32'hDEADBEEF);
      tick();
      cs = 1'b0;
      check("lat_a_t1", {31'h0, bus_a.read_valid}, 32'h1);
      check("lat_b_t1", {31'h0, bus_b.read_valid}, 32'h0);
      tick();
      check("lat_a_t2", {31'h0, bus_a.read_valid}, 32'h0);
      check("lat_b_t2", {31'h0, bus_b.read_valid}, 32'h1);
      tick();
      check("lat_b_t3", {31'h0, bus_b.read_valid}, 32'h0);
    end
    oe = 1'b1;
    #1;
    check("hold_a", bus_a.read_data, 32'hDEADBEEF);
    check("hold_b", bus_b.read_data, 32'hDEADBEEF);

    // Back-to-back reads come out in order.
    op_write(10'd4, 32'h01020304, 4'hF);
    cs = 1'b1; rd = 1'b1; addr = 10'd3;
    qa.push_back(32'hDEADBEEF);
    qb.push_back(32'hDEADBEEF);
    tick();
    addr = 10'd4;
    qa.push_back(32'h01020304);
    qb.push_back(32'h01020304);
    tick();
    cs = 1'b0;
    repeat (3) tick();

    // 16-bit no-clear instance.
    c_cs = 1'b1; c_rd = 1'b0; c_addr = 4'd15; c_wdat = 16'hBEEF; c_be = 2'b11;
    tick();
    c_rd = 1'b1;
    qc.push_back(32'h0000BEEF);
    tick();
    c_rd = 1'b0; c_wdat = 16'h1234; c_be = 2'b10;
    tick();
    c_rd = 1'b1;
    qc.push_back(32'h000012EF);
    tick();
    c_cs = 1'b0;
    repeat (2) tick();

    // Reset while a READ_LAT=2 read is in flight drops it.
    cs = 1'b1; rd = 1'b1; addr = 10'd3;
    qa.push_back(32'hDEADBEEF);
    tick();
    cs = 1'b0;
    rst = 1'b1;
    #1;
    check("midread_vld_b_rst", {31'h0, bus_b.read_valid}, 32'h0);
    tick();
    check("midread_vld_b_next", {31'h0, bus_b.read_valid}, 32'h0);
    rst = 1'b0;
    repeat (4) tick();

    check("qa_drained", qa.size(), 32'd0);
    check("qb_drained", qb.size(), 32'd0);
    check("qc_drained", qc.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
